rx_frame_assembler: RTL and testbench
=====================================

# rx_frame_assembler

- Receive-path stage downstream of the 8b10b decoder for the TJ-Monopix2 serial link.
- Consumes decoded bytes with K-flags.
- Recognises chip frames delimited by SOF/EOF comma symbols, packs each 4-byte hit into one 32-bit FIFO word, and closes every frame with a trailer word carrying counters and error flags.
- Output is a valid/ready stream that feeds the readout arbiter ahead of the BRAM FIFO.

## Interface
Parameters:
- HEADER, 4'h0: value placed in bits [31:28] of every output word.
- K_SOF, 8'h3C: K-symbol (K28.1) opening a frame.
- K_EOF, 8'hBC: K-symbol (K28.5) closing a frame; it is also the idle symbol outside frames.

Ports:
- CLK, in, 1: single clock; all logic is in this domain.
- RESETB, in, 1: asynchronous active-low reset; deassertion is synchronous to CLK.
- DATA_IN, in, 8: decoded byte.
- DATA_K, in, 1: DATA_IN is a K-symbol.
- DATA_VALID, in, 1: byte strobe; at most one byte per cycle, no backpressure.
- DECODER_ERR, in, 1: code or disparity error on this byte; qualified by DATA_VALID.
- FIFO_DATA, out, 32: output word; 0 in reset.
- FIFO_VALID, out, 1: FIFO_DATA is valid; 0 in reset.
- FIFO_READ, in, 1: consumer pops the word when FIFO_VALID && FIFO_READ.
- FRAME_ACTIVE, out, 1: high between SOF and EOF; 0 in reset.
- OVERFLOW_CNT, out, 16: count of words dropped because the FIFO was full; saturates at 16'hFFFF; 0 in reset.

## Operation
- States: IDLE, FRAME.
- IDLE:
  - A valid K_SOF moves to FRAME and clears byte_idx, hit_cnt and err.
  - All other bytes are ignored, including a non-K byte, K_EOF, or a byte with DECODER_ERR.
- FRAME, valid non-K byte:
  - The byte is shifted into hit_sr[31:0], MSB-first. The first byte becomes hit[31:24].
  - byte_idx increments modulo 4.
  - On the 4th byte, push {HEADER, 1'b0, hit[26:0]}.
  - If hit[31:27] != 0, set err[0] (pad violation). The word is still pushed.
  - hit_cnt increments and saturates at 16'hFFFF.
- FRAME, valid K_EOF:
  - If byte_idx != 0, set err[1] (truncated hit); the partial bytes are discarded.
  - Push trailer {HEADER, 1'b1, err[2:0], frame_cnt[7:0], hit_cnt[15:0]}. err here includes any flag set by this same EOF.
  - frame_cnt increments and wraps at 8 bits.
  - Go to IDLE.
- FRAME, valid K_SOF, any other K-symbol, or DECODER_ERR:
  - Set err[2] (framing error).
  - Push the trailer exactly as for EOF. The partial hit is discarded and frame_cnt increments.
  - A K_SOF then re-enters FRAME in the same cycle with freshly cleared counters. Anything else goes to IDLE.
- Push when the FIFO is full:
  - The word is dropped and OVERFLOW_CNT increments.
  - Framing state advances as normal.
- Pushes are at most one per cycle, because a hit word and a trailer cannot arise from the same byte.
- frame_cnt resets to 0 and is never cleared otherwise.

## Timing
- A word pushed on edge N (the edge sampling its last byte or its EOF) is visible on FIFO_DATA/FIFO_VALID after edge N+1. Latency is one cycle; the FIFO is show-ahead.
- FIFO depth is 4.
- Push and pop in the same cycle on a full FIFO: the pop frees the slot, the push is accepted, and nothing is dropped.
- FIFO_DATA is stable while FIFO_VALID && !FIFO_READ.
- FIFO_READ while FIFO_VALID=0 is ignored.
- FRAME_ACTIVE rises one cycle after K_SOF is sampled and falls one cycle after EOF or error.
- RESETB asserted mid-frame:
  - Immediately returns the block to IDLE and empties the FIFO.
  - Zeroes every output, counter and flag.
  - No trailer is emitted.

## Structure
- Package rx_frame_pkg holds:
  - the state enum {IDLE, FRAME};
  - the default K_SOF/K_EOF constants;
  - the err bit indices ERR_PAD=0, ERR_TRUNC=1, ERR_FRAMING=2;
  - the word-type bit position 27.
- Sub-module rx_frame_fifo: 4×32 synchronous show-ahead FIFO with full/empty flags, same CLK/RESETB.
- Top level contains the FSM, shift register, counters and overflow logic.
- Expected size: about 200 lines of RTL.

## Test plan
- Single hit:
  - Stimulus: SOF, 8'h01 8'h23 8'h45 8'h67, EOF, FIFO_READ held high.
  - Required response: word 32'h0123_4567 with the header substituted, i.e. {4'h0, 1'b0, 27'h123_4567}.
  - Then trailer {4'h0, 1'b1, 3'b000, 8'h00, 16'h0001}.
- Truncated hit: SOF, 3 data bytes, EOF -> only a trailer, err=3'b010, hit_cnt=0; frame_cnt in the next frame's trailer is 1.
- Framing error:
  - Stimulus: SOF, 4 bytes, SOF, 4 bytes, EOF.
  - Required response: hit, trailer with err=3'b100 and hit_cnt=1, hit, trailer with err=0 and frame_cnt=1.
- Backpressure:
  - Stimulus: FIFO_READ=0; one frame of 5 hits.
  - Required response: 4 words retained; the 5th hit and the trailer are dropped; OVERFLOW_CNT=2.
  - After releasing FIFO_READ, the 4 hits drain in order.
- Pad and decoder error: hit byte0=8'hF8 -> err[0] set in the trailer. DECODER_ERR on a mid-frame byte -> trailer with err[2] and return to IDLE.
- Reset mid-frame: assert RESETB after 2 data bytes -> FIFO_VALID=0, FRAME_ACTIVE=0, OVERFLOW_CNT=0, no trailer; the next SOF frame produces frame_cnt=0.

Source files
------------

// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the TJ-Monopix2 receive frame assembler.
package rx_frame_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    localparam logic [7:0] K_SOF_DEF = 8'h3C;
    localparam logic [7:0] K_EOF_DEF = 8'hBC;

    localparam int ERR_PAD     = 0;
    localparam int ERR_TRUNC   = 1;
    localparam int ERR_FRAMING = 2;

    // Set in trailer words, clear in hit words.
    localparam int WORD_TYPE_BIT = 27;

endpackage

// File: rtl/rx_frame_fifo.sv
// 4x32 show-ahead FIFO; the head word is presented combinationally while not empty.
module rx_frame_fifo (
    input  logic        CLK,
    input  logic        RESETB,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        full,
    output logic        empty
);

    logic [31:0] mem_reg [4];
    logic [1:0]  wr_ptr_reg;
    logic [1:0]  rd_ptr_reg;
    logic [2:0]  count_reg;
    logic        do_push;
    logic        do_pop;

    assign full    = (count_reg == 3'd4);
    assign empty   = (count_reg == 3'd0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? 32'h0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rx_frame_assembler.sv
// Packs 8b10b-decoded frame bytes into 32-bit hit words and a closing trailer word,
// buffered through a small show-ahead FIFO toward the readout arbiter.
module rx_frame_assembler
    import rx_frame_pkg::*;
#(
    parameter logic [3:0] HEADER = 4'h0,
    parameter logic [7:0] K_SOF  = K_SOF_DEF,
    parameter logic [7:0] K_EOF  = K_EOF_DEF
) (
    input  logic        CLK,
    input  logic        RESETB,
    input  logic [7:0]  DATA_IN,
    input  logic        DATA_K,
    input  logic        DATA_VALID,
    input  logic        DECODER_ERR,
    output logic [31:0] FIFO_DATA,
    output logic        FIFO_VALID,
    input  logic        FIFO_READ,
    output logic        FRAME_ACTIVE,
    output logic [15:0] OVERFLOW_CNT
);

    state_t      state_reg, state_next;
    logic [1:0]  byte_idx_reg, byte_idx_next;
    logic [23:0] hit_sr_reg, hit_sr_next;
    logic [15:0] hit_cnt_reg, hit_cnt_next;
    logic [2:0]  err_reg, err_next;
    logic [7:0]  frame_cnt_reg, frame_cnt_next;
    logic        push_reg, push_next;
    logic [31:0] push_word_reg, push_word_next;
    logic [15:0] ovf_cnt_reg;

    logic [31:0] hit_word;
    logic [31:0] hit_out;
    logic [31:0] trailer_out;
    logic [2:0]  err_close;
    logic        is_sof, take_byte, close_frame, open_frame;
    logic        fifo_full, fifo_empty, fifo_pop;
    logic [31:0] fifo_head;

    assign hit_word    = {hit_sr_reg, DATA_IN};
    assign is_sof      = DATA_K && (DATA_IN == K_SOF) && !DECODER_ERR;
    assign take_byte   = DATA_VALID && (state_reg == FRAME) && !DATA_K && !DECODER_ERR;
    assign close_frame = DATA_VALID && (state_reg == FRAME) && (DATA_K || DECODER_ERR);
    assign open_frame  = DATA_VALID && is_sof;

    // FSM: state register
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state; an SOF inside a frame closes it and reopens in the same cycle
    always_comb begin
        state_next = state_reg;
        if (DATA_VALID) begin
            case (state_reg)
                IDLE:    if (is_sof) state_next = FRAME;
                FRAME:   if (DATA_K || DECODER_ERR) state_next = is_sof ? FRAME : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        FRAME_ACTIVE = (state_reg == FRAME);
    end

    always_comb begin
        byte_idx_next  = byte_idx_reg;
        hit_sr_next    = hit_sr_reg;
        hit_cnt_next   = hit_cnt_reg;
        err_next       = err_reg;
        frame_cnt_next = frame_cnt_reg;
        push_next      = 1'b0;
        push_word_next = push_word_reg;

        err_close = err_reg;
        if (byte_idx_reg != 2'd0) err_close[ERR_TRUNC] = 1'b1;
        if (DECODER_ERR || (DATA_IN != K_EOF)) err_close[ERR_FRAMING] = 1'b1;

        hit_out = {HEADER, hit_word[27:0]};
        hit_out[WORD_TYPE_BIT] = 1'b0;
        trailer_out = {HEADER, 1'b0, err_close, frame_cnt_reg, hit_cnt_reg};
        trailer_out[WORD_TYPE_BIT] = 1'b1;

        if (take_byte) begin
            hit_sr_next   = hit_word[23:0];
            byte_idx_next = byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
                push_next      = 1'b1;
                push_word_next = hit_out;
                if (hit_word[31:27] != 5'd0) err_next[ERR_PAD] = 1'b1;
                if (hit_cnt_reg != 16'hFFFF) hit_cnt_next = hit_cnt_reg + 16'd1;
            end
        end
        if (close_frame) begin
            push_next      = 1'b1;
            push_word_next = trailer_out;
            err_next       = err_close;
            frame_cnt_next = frame_cnt_reg + 8'd1;
        end
        if (open_frame) begin
            byte_idx_next = 2'd0;
            hit_cnt_next  = 16'd0;
            err_next      = 3'd0;
        end
    end

    assign fifo_pop = FIFO_READ && !fifo_empty;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            byte_idx_reg  <= 2'd0;
            hit_sr_reg    <= 24'd0;
            hit_cnt_reg   <= 16'd0;
            err_reg       <= 3'd0;
            frame_cnt_reg <= 8'd0;
            push_reg      <= 1'b0;
            push_word_reg <= 32'd0;
            ovf_cnt_reg   <= 16'd0;
        end else begin
            byte_idx_reg  <= byte_idx_next;
            hit_sr_reg    <= hit_sr_next;
            hit_cnt_reg   <= hit_cnt_next;
            err_reg       <= err_next;
            frame_cnt_reg <= frame_cnt_next;
            push_reg      <= push_next;
            push_word_reg <= push_word_next;
            if (push_reg && fifo_full && !fifo_pop && (ovf_cnt_reg != 16'hFFFF)) begin
                ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
            end
        end
    end

    rx_frame_fifo u_fifo (
        .CLK       (CLK),
        .RESETB    (RESETB),
        .push      (push_reg),
        .push_data (push_word_reg),
        .pop       (FIFO_READ),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign FIFO_DATA    = fifo_head;
    assign FIFO_VALID   = !fifo_empty;
    assign OVERFLOW_CNT = ovf_cnt_reg;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Directed bench for rx_frame_assembler: hits, trailers, errors, backpressure and reset.
module tb_rx_frame_assembler;

    localparam logic [7:0] SOF = 8'h3C;
    localparam logic [7:0] EOF = 8'hBC;

    logic        CLK = 1'b0;
    logic        RESETB;
    logic [7:0]  DATA_IN;
    logic        DATA_K;
    logic        DATA_VALID;
    logic        DECODER_ERR;
    logic [31:0] FIFO_DATA;
    logic        FIFO_VALID;
    logic        FIFO_READ;
    logic        FRAME_ACTIVE;
    logic [15:0] OVERFLOW_CNT;

    int checks   = 0;
    int failures = 0;
    logic [31:0] got_q [$];

    rx_frame_assembler dut (
        .CLK          (CLK),
        .RESETB       (RESETB),
        .DATA_IN      (DATA_IN),
        .DATA_K       (DATA_K),
        .DATA_VALID   (DATA_VALID),
        .DECODER_ERR  (DECODER_ERR),
        .FIFO_DATA    (FIFO_DATA),
        .FIFO_VALID   (FIFO_VALID),
        .FIFO_READ    (FIFO_READ),
        .FRAME_ACTIVE (FRAME_ACTIVE),
        .OVERFLOW_CNT (OVERFLOW_CNT)
    );

    always #5 CLK = ~CLK;

    // Record every popped word, sampled half a cycle before the popping edge.
    always @(negedge CLK) begin
        if (RESETB && FIFO_VALID && FIFO_READ) got_q.push_back(FIFO_DATA);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send(input logic k, input logic [7:0] d, input logic e);
        DATA_K = k; DATA_IN = d; DECODER_ERR = e; DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        DATA_VALID = 1'b0; DATA_K = 1'b0; DECODER_ERR = 1'b0; DATA_IN = 8'h00;
    endtask

    task automatic send_hit(input logic [31:0] w);
        send(1'b0, w[31:24], 1'b0);
        send(1'b0, w[23:16], 1'b0);
        send(1'b0, w[15:8],  1'b0);
        send(1'b0, w[7:0],   1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic expect_word(input string tag, input logic [31:0] exp);
        int n = 0;
        logic [31:0] w;
        while (got_q.size() == 0 && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        if (got_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=timeout expected=%h", tag, exp);
        end else begin
            w = got_q.pop_front();
            check(tag, w, exp);
        end
    endtask

    initial begin
        RESETB = 1'b0; DATA_IN = 8'h00; DATA_K = 1'b0; DATA_VALID = 1'b0;
        DECODER_ERR = 1'b0; FIFO_READ = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_valid", 32'(FIFO_VALID), 32'd0);
        check("rst_data", FIFO_DATA, 32'd0);
        check("rst_active", 32'(FRAME_ACTIVE), 32'd0);
        check("rst_ovf", 32'(OVERFLOW_CNT), 32'd0);
        RESETB = 1'b1;
        idle(2);

        // Single hit, with one-cycle latency into the FIFO.
        FIFO_READ = 1'b1;
        send(1'b1, SOF, 1'b0);
        check("t1_active_rise", 32'(FRAME_ACTIVE), 32'd1);
        send_hit(32'h0123_4567);
        check("t1_latency_n", 32'(FIFO_VALID), 32'd0);
        send(1'b1, EOF, 1'b0);
        check("t1_latency_n1", 32'(FIFO_VALID), 32'd1);
        check("t1_head", FIFO_DATA, 32'h0123_4567);
        check("t1_active_fall", 32'(FRAME_ACTIVE), 32'd0);
        expect_word("t1_hit", 32'h0123_4567);
        expect_word("t1_trailer", 32'h0800_0001);

        // Truncated hit.
        send(1'b1, SOF, 1'b0);
        send(1'b0, 8'hAA, 1'b0);
        send(1'b0, 8'hBB, 1'b0);
        send(1'b0, 8'hCC, 1'b0);
        send(1'b1, EOF, 1'b0);
        expect_word("t2_trailer", 32'h0A01_0000);
        idle(3);
        check("t2_noextra", 32'(got_q.size()), 32'd0);

        // Framing error by a second SOF, then a clean frame.
        send(1'b1, SOF, 1'b0);
        send_hit(32'h0102_0304);
        send(1'b1, SOF, 1'b0);
        send_hit(32'h0506_0708);
        send(1'b1, EOF, 1'b0);
        expect_word("t3_hit_a", 32'h0102_0304);
        expect_word("t3_trailer_a", 32'h0C02_0001);
        expect_word("t3_hit_b", 32'h0506_0708);
        expect_word("t3_trailer_b", 32'h0803_0001);

        // Backpressure: 5 hits into a depth-4 FIFO.
        FIFO_READ = 1'b0;
        send(1'b1, SOF, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            send_hit({4{8'(i)}});
        end
        send(1'b1, EOF, 1'b0);
        idle(2);
        check("t4_ovf", 32'(OVERFLOW_CNT), 32'd2);
        check("t4_valid", 32'(FIFO_VALID), 32'd1);
        check("t4_head", FIFO_DATA, 32'h0101_0101);
        idle(3);
        check("t4_head_stable", FIFO_DATA, 32'h0101_0101);
        FIFO_READ = 1'b1;
        expect_word("t4_w1", 32'h0101_0101);
        expect_word("t4_w2", 32'h0202_0202);
        expect_word("t4_w3", 32'h0303_0303);
        expect_word("t4_w4", 32'h0404_0404);
        idle(2);
        check("t4_drained", 32'(FIFO_VALID), 32'd0);
        check("t4_noextra", 32'(got_q.size()), 32'd0);

        // Pad violation.
        send(1'b1, SOF, 1'b0);
        send_hit(32'hF800_0001);
        send(1'b1, EOF, 1'b0);
        expect_word("t5_pad_hit", 32'h0000_0001);
        expect_word("t5_pad_trailer", 32'h0905_0001);

        // Decoder error mid-frame, then bytes outside a frame are ignored.
        send(1'b1, SOF, 1'b0);
        send_hit(32'h0102_0304);
        send(1'b0, 8'h09, 1'b1);
        check("t5_err_idle", 32'(FRAME_ACTIVE), 32'd0);
        send_hit(32'h0102_0304);
        send(1'b1, EOF, 1'b0);
        expect_word("t5_err_hit", 32'h0102_0304);
        expect_word("t5_err_trailer", 32'h0C06_0001);
        idle(4);
        check("t5_ignored", 32'(got_q.size()), 32'd0);

        // Reset in the middle of a frame with a word held in the FIFO.
        FIFO_READ = 1'b0;
        send(1'b1, SOF, 1'b0);
        send_hit(32'h0102_0304);
        send(1'b0, 8'h0A, 1'b0);
        send(1'b0, 8'h0B, 1'b0);
        idle(1);
        check("t6_pre_valid", 32'(FIFO_VALID), 32'd1);
        RESETB = 1'b0;
        #1;
        check("t6_valid", 32'(FIFO_VALID), 32'd0);
        check("t6_data", FIFO_DATA, 32'd0);
        check("t6_active", 32'(FRAME_ACTIVE), 32'd0);
        check("t6_ovf", 32'(OVERFLOW_CNT), 32'd0);
        @(posedge CLK); #1;
        RESETB = 1'b1;
        FIFO_READ = 1'b1;
        idle(2);
        check("t6_no_trailer", 32'(got_q.size()), 32'd0);
        send(1'b1, SOF, 1'b0);
        send_hit(32'h0102_0304);
        send(1'b1, EOF, 1'b0);
        expect_word("t6_hit", 32'h0102_0304);
        expect_word("t6_trailer", 32'h0800_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
